// File: rtl/data_memory_hs.sv
// -----------------------------------------------------------------------------
// data_memory_hs
// Single-port word memory behind a req/ready/ack handshake. One access is in
// flight at a time: a request accepted in IDLE spends WAIT_STATES cycles in
// WAIT, then one cycle in RESP where ack pulses with err and rdata.
//
// Parameters
//   DATA_W      word width in bits (multiple of 8)
//   DEPTH       number of words (power of two)
//   ADDR_W      byte-address width
//   WAIT_STATES extra access cycles (0..15)
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   access request, sampled only while ready=1
//   we       in   1 = write, 0 = read
//   addr     in   byte address
//   wdata    in   write data
//   byte_en  in   per-byte write enable
//   ready    out  request can be accepted this cycle
//   ack      out  one-cycle completion pulse
//   rdata    out  read data, held until the next successful read
//   err      out  misaligned or out-of-range access, valid with ack
//
// Build option
//   DATA_MEMORY_HS_INIT_EN  when defined, words 0..5 start as
//                           1000, 200, 300, 400, 200, 3 and all others 0.
//
// States
//   ST_IDLE | ready high, waiting for req
//   ST_WAIT | access in progress, down-counter running
//   ST_RESP | ack pulse, memory write / rdata load happened on entry
// -----------------------------------------------------------------------------
module data_memory_hs #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic                ready,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BYTES-1:0]    r_be;

`ifdef DATA_MEMORY_HS_INIT_EN
    logic [DATA_W-1:0]   r_mem [DEPTH] = '{
        0: DATA_W'(1000),
        1: DATA_W'(200),
        2: DATA_W'(300),
        3: DATA_W'(400),
        4: DATA_W'(200),
        5: DATA_W'(3),
        default: '0
    };
`else
    logic [DATA_W-1:0]   r_mem [DEPTH];
`endif

    // In IDLE the request fields come straight from the pins, so that with
    // WAIT_STATES=0 the access can complete on its own acceptance edge.
    // Otherwise the captured copies are used.
    logic                w_live;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [BYTES-1:0]    w_be;
    logic [ADDR_W:0]     w_index_full;
    logic [MEM_AW-1:0]   w_word;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_bad;
    logic                w_to_resp;
    logic                w_mem_wr;

    assign w_live         = (r_state == ST_IDLE);
    assign w_we           = w_live ? we      : r_we;
    assign w_addr         = w_live ? addr    : r_addr;
    assign w_wdata        = w_live ? wdata   : r_wdata;
    assign w_be           = w_live ? byte_en : r_be;

    // One extra index bit so DEPTH itself is representable in the compare.
    assign w_index_full   = {1'b0, w_addr} >> OFF_W;
    assign w_word         = w_index_full[MEM_AW-1:0];
    assign w_misaligned   = (w_addr & ADDR_W'(BYTES - 1)) != '0;
    assign w_out_of_range = w_index_full >= (ADDR_W + 1)'(DEPTH);
    assign w_bad          = w_misaligned || w_out_of_range;

    assign w_to_resp = ((r_state == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == '0));

    // Gating with reset_n keeps a write from landing while reset is held.
    assign w_mem_wr  = reset_n && w_to_resp && w_we && !w_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_be    <= byte_en;
                        r_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_bad;
                            if (!we && !w_bad) begin
                                r_rdata <= r_mem[w_word];
                            end
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_bad;
                        if (!r_we && !w_bad) begin
                            r_rdata <= r_mem[w_word];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset: contents survive reset_n.
    always_ff @(posedge clock) begin
        if (w_mem_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = r_ready;
    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_data_memory_hs.sv
// -----------------------------------------------------------------------------
// tb_data_memory_hs
// Randomised bench for data_memory_hs. A plain array holds the expected memory
// image; every access is predicted from the address/byte-enable rules and the
// handshake timing (ack in the (WAIT_STATES+1)th cycle after acceptance, next
// acceptance WAIT_STATES+2 edges later). A second instance with WAIT_STATES=0
// covers the back-to-back path.
// -----------------------------------------------------------------------------
module tb_data_memory_hs;

    localparam int WS = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        ready, ack, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [11:0] addr0;
    logic [31:0] wdata0;
    logic [3:0]  byte_en0;
    logic        ready0, ack0, err0;
    logic [31:0] rdata0;

    always #5 clock = ~clock;

    data_memory_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(12), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .ready(ready), .ack(ack),
        .rdata(rdata), .err(err)
    );

    data_memory_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(12), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .byte_en(byte_en0), .ready(ready0), .ack(ack0),
        .rdata(rdata0), .err(err0)
    );

    logic [31:0] ref_mem [128];
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Starts at a negedge with the DUT idle, ends at the negedge where the
    // next request may be driven.
    task automatic access(input logic t_we, input logic [11:0] t_addr,
                          input logic [31:0] t_wdata, input logic [3:0] t_be);
        logic       bad;
        logic [9:0] widx;
        widx = t_addr[11:2];
        bad  = (t_addr[1:0] != 2'b00) || (widx >= 10'd128);
        check("ready_idle", ready, 1'b1);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; byte_en = t_be;
        if (!bad) begin
            if (t_we) begin
                for (int b = 0; b < 4; b++)
                    if (t_be[b]) ref_mem[widx[6:0]][8*b +: 8] = t_wdata[8*b +: 8];
            end else begin
                exp_rdata = ref_mem[widx[6:0]];
            end
        end
        for (int k = 1; k <= WS + 1; k++) begin
            @(negedge clock);
            check("ack", ack, (k == WS + 1));
            check("ready_busy", ready, 1'b0);
            if (k == WS + 1) begin
                check("err", err, bad);
                check("rdata", rdata, exp_rdata);
            end else begin
                check("err_quiet", err, 1'b0);
            end
            // Traffic while busy must be ignored.
            req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            addr = 12'($urandom); wdata = $urandom; byte_en = 4'($urandom);
        end
        @(negedge clock);
        req = 1'b0;
        check("ack_drop", ack, 1'b0);
        check("err_drop", err, 1'b0);
        check("rdata_hold", rdata, exp_rdata);
    endtask

    // Accept a write, then pulse reset at the given WAIT cycle (1..WS).
    task automatic abort_write(input logic [11:0] t_addr, input logic [31:0] t_wdata, input int at_cycle);
        check("ready_idle", ready, 1'b1);
        req = 1'b1; we = 1'b1; addr = t_addr; wdata = t_wdata; byte_en = 4'hF;
        for (int k = 1; k <= at_cycle; k++) begin
            @(negedge clock);
            req = 1'b0;
            check("abort_no_ack", ack, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_ack", ack, 1'b0);
        check("abort_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < WS + 2; k++) begin
            @(negedge clock);
            check("abort_quiet", ack, 1'b0);
        end
    endtask

    initial begin
        int          cnt_ack;
        logic [11:0] a;
        reset_n = 1'b0;
        req = 0; we = 0; addr = '0; wdata = '0; byte_en = '0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; byte_en0 = '0;
        exp_rdata = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_ready", ready, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready0", ready0, 1'b1);
        reset_n = 1'b1;

        // First request goes in on the first edge after release.
        for (int w = 0; w < 128; w++) access(1'b1, 12'(w * 4), $urandom, 4'hF);

        // Byte-lane merge.
        access(1'b1, 12'h010, 32'h11223344, 4'hF);
        access(1'b1, 12'h010, 32'hAABBCCDD, 4'b0101);
        access(1'b0, 12'h010, 32'h0, 4'h0);
        check("lane_merge", rdata, 32'h11BB33DD);
        access(1'b1, 12'h010, 32'hFFFFFFFF, 4'h0);
        access(1'b0, 12'h010, 32'h0, 4'h0);
        check("be_zero", rdata, 32'h11BB33DD);

        // Error accesses: no rdata load, no memory change.
        access(1'b0, 12'h002, 32'h0, 4'h0);
        access(1'b0, 12'h200, 32'h0, 4'h0);
        check("err_hold", rdata, 32'h11BB33DD);
        access(1'b1, 12'h011, 32'h0, 4'hF);
        access(1'b1, 12'h200, 32'h0, 4'hF);
        access(1'b0, 12'h010, 32'h0, 4'h0);
        check("err_nowrite", rdata, 32'h11BB33DD);
        access(1'b0, 12'h000, 32'h0, 4'h0);

        // Reset during WAIT aborts the write.
        abort_write(12'h010, 32'h55667788, 1);
        access(1'b0, 12'h010, 32'h0, 4'h0);
        check("abort_keep", rdata, 32'h11BB33DD);
        abort_write(12'h020, 32'h99999999, WS);
        access(1'b0, 12'h020, 32'h0, 4'h0);

        // Random traffic including misaligned, out-of-range and be=0.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = {5'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
                1:       a = {10'($urandom_range(128, 1023)), 2'b00};
                default: a = {3'b000, 7'($urandom_range(0, 127)), 2'b00};
            endcase
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // WAIT_STATES=0 instance: req held for 6 edges, accepts every other edge.
        cnt_ack = 0;
        for (int k = 0; k <= 6; k++) begin
            req0 = (k < 6); we0 = 1'b1; byte_en0 = 4'hF;
            addr0 = 12'(32'h40 + (k / 2) * 4); wdata0 = 32'(32'h100 + k);
            @(negedge clock);
            check("ws0_ack", ack0, (k % 2 == 0) && (k < 6));
            check("ws0_ready", ready0, !((k % 2 == 0) && (k < 6)));
            check("ws0_err", err0, 1'b0);
            cnt_ack += int'(ack0);
        end
        check("ws0_count", 64'(cnt_ack), 64'd3);
        for (int k = 0; k <= 6; k++) begin
            req0 = (k < 6); we0 = 1'b0;
            addr0 = 12'(32'h40 + (k / 2) * 4);
            @(negedge clock);
            check("ws0_rd_ack", ack0, (k % 2 == 0) && (k < 6));
            if ((k % 2 == 0) && (k < 6)) check("ws0_rdata", rdata0, 32'(32'h100 + k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
